// File: rtl/instr_mem.sv
// Instruction memory with a single-cycle fetch port, a program-load write port and
// an optional zero sweep after reset (CLEAR) before fetches and loads are accepted (READY).
module instr_mem #(
    parameter int ADDR_W     = 14,
    parameter int DEPTH      = 29,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_stall,
    output logic              f_ready,
    output logic              f_valid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_err,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W + 1)'(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_RESET = INIT_CLEAR ? ST_CLEAR : ST_READY;

    logic [0:0]       state;
    logic [PTR_W-1:0] sweep_ptr;
    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ld_idx;
    logic [PTR_W-1:0] f_ptr;
    logic [PTR_W-1:0] ld_ptr;
    logic             f_hit;
    logic             ld_hit;
    logic             f_accept;
    logic             ld_accept;
    logic [31:0]      f_word;

    assign f_idx  = f_addr[ADDR_W-1:2];
    assign ld_idx = ld_addr[ADDR_W-1:2];
    assign f_ptr  = f_idx[PTR_W-1:0];
    assign ld_ptr = ld_idx[PTR_W-1:0];

    // A hit is an aligned address whose word index falls inside the array.
    assign f_hit  = ({1'b0, f_idx} < DEPTH_L) && (f_addr[1:0] == 2'b00);
    assign ld_hit = ({1'b0, ld_idx} < DEPTH_L) && (ld_addr[1:0] == 2'b00);

    assign busy      = (state == ST_CLEAR);
    assign f_ready   = (state == ST_READY) && !f_stall;
    assign f_accept  = f_req && f_ready;
    assign ld_accept = ld_we && (state == ST_READY) && ld_hit;

    // Write-first: a load landing on the word being fetched is forwarded.
    assign f_word = !f_hit                          ? 32'h0   :
                    (ld_accept && ld_idx == f_idx)  ? ld_data :
                                                      mem[f_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            sweep_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            if (sweep_ptr == PTR_LAST) begin
                state     <= ST_READY;
                sweep_ptr <= '0;
            end else begin
                sweep_ptr <= sweep_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the sweep or program loads define it.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[sweep_ptr] <= 32'h0;
        end else if (ld_accept) begin
            mem[ld_ptr] <= ld_data;
        end
    end

    // A stalled consumer freezes the whole response; otherwise valid tracks acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_valid <= 1'b0;
            f_rdata <= 32'h0;
            f_err   <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            ld_err <= ld_we && !ld_accept;
            if (!f_stall) begin
                if (f_accept) begin
                    f_valid <= 1'b1;
                    f_rdata <= f_word;
                    f_err   <= !f_hit;
                end else begin
                    f_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter ADDR_W, default 14, byte-address width of the fetch and load ports.
REQ-002 Parameter DEPTH, default 29, number of 32-bit words; SHALL satisfy 1 <= DEPTH <= 2^(ADDR_W-2).
REQ-003 Parameter INIT_CLEAR, default 1, 1 = zero-sweep memory after reset, 0 = skip sweep.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 f_req  input  1  fetch request.
REQ-007 f_addr  input  ADDR_W  fetch byte address.
REQ-008 f_stall  input  1  consumer stall; hold fetch output.
REQ-009 f_ready  output  1  fetch request accepted this cycle when high with f_req.
REQ-010 f_valid  output  1  f_rdata/f_err valid.
REQ-011 f_rdata  output  32  fetched instruction word.
REQ-012 f_err  output  1  fetch fault (out of range or misaligned).
REQ-013 ld_we  input  1  program-load write strobe.
REQ-014 ld_addr  input  ADDR_W  load byte address.
REQ-015 ld_data  input  32  load word.
REQ-016 ld_err  output  1  one-cycle pulse: rejected load write.
REQ-017 busy  output  1  high while in CLEAR state.

Function
REQ-018 Word index SHALL be addr[ADDR_W-1:2] for both ports; addr[1:0] != 0 is misaligned.
REQ-019 FSM states: CLEAR, READY; after reset state SHALL be CLEAR if INIT_CLEAR=1, else READY.
REQ-020 CLEAR: sweep counter writes 32'h0 to word 0..DEPTH-1, one word per cycle; after writing word DEPTH-1 state SHALL be READY next cycle (CLEAR lasts exactly DEPTH cycles).
REQ-021 busy SHALL equal (state == CLEAR).
REQ-022 f_ready SHALL equal (state == READY) && !f_stall.
REQ-023 Fetch accepted (f_req && f_ready) at edge N SHALL give f_valid=1 with f_rdata/f_err at cycle N+1 (latency 1).
REQ-024 Cycle with f_stall=1: f_valid, f_rdata, f_err SHALL hold previous values; no new fetch accepted.
REQ-025 Cycle with f_stall=0 and no accepted fetch: f_valid SHALL go 0 next cycle; f_rdata/f_err hold.
REQ-026 Fetch with index >= DEPTH or misaligned: f_rdata SHALL be 32'h0, f_err=1; otherwise f_err=0, f_rdata = stored word.
REQ-027 Load write accepted only when state == READY, index < DEPTH, addr aligned; writes word at next edge.
REQ-028 Rejected ld_we (CLEAR state, out of range, misaligned) SHALL not modify memory and SHALL pulse ld_err=1 the following cycle.
REQ-029 Same-cycle accepted fetch and load to same index: f_rdata SHALL return ld_data (write-first bypass).
REQ-030 Memory array SHALL not be reset directly; contents after reset defined only via CLEAR sweep or loads.

Reset
REQ-031 rst_n low SHALL immediately force f_valid=0, f_rdata=0, f_err=0, ld_err=0, sweep counter=0, state per REQ-019.
REQ-032 Reset asserted mid-CLEAR or mid-fetch SHALL abort the operation; sweep restarts from word 0 after release.
REQ-033 Outputs SHALL reach reset values combinationally with rst_n fall, independent of clk.

Verification (DEPTH=32, ADDR_W=14, INIT_CLEAR=1)
REQ-034 Release reset -> busy=1 for exactly 32 cycles, f_ready=0 throughout; then busy=0, f_ready=1; fetch 0x04 -> f_rdata=0, f_err=0.
REQ-035 ld_we to 0x08 data 32'h0100026f, then fetch 0x08 -> next cycle f_valid=1, f_rdata=32'h0100026f, f_err=0.
REQ-036 Fetch 0x80 (index 32) -> f_rdata=0, f_err=1; fetch 0x06 -> f_rdata=0, f_err=1; ld_we to 0x80 -> ld_err pulse, memory unchanged.
REQ-037 Fetch 0x08 then f_stall=1 for 3 cycles with f_req=1, f_addr=0x0c -> f_rdata held at word 2, f_ready=0; stall drop -> 0x0c fetched one cycle later.
REQ-038 Same cycle ld_we 0x10 data 32'h00000013 and fetch 0x10 -> f_rdata=32'h00000013.
REQ-039 rst_n pulse at sweep word 10 -> outputs zeroed immediately, busy=1 for full 32 cycles after release; ld_we during CLEAR -> ld_err pulse.
